// File: rtl/mul_div_hilo_if.sv
// Operand/handshake and HI/LO bus bundle for the iterative multiply/divide unit.
// The master drives operands and bus writes; the slave owns HI, LO and status.
interface mul_div_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] bus_in;
  logic             HIin;
  logic             LOWin;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, opa, opb, bus_in, HIin, LOWin,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, opa, opb, bus_in, HIin, LOWin,
    output hi, lo, busy, done, div_by_zero
  );
endinterface

// File: rtl/mul_div_hilo.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring, on magnitudes)
// that owns the HI and LO registers; fixed latency of WIDTH+1 edges per operation.
module mul_div_hilo #(
  parameter int WIDTH = 32
) (
  input logic           Clock,
  input logic           Clear,
  mul_div_hilo_if.slave md
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt;
  logic             op_q, quo_neg_q, rem_neg_q, zero_q;
  logic [WIDTH-1:0] m_q;          // Booth multiplicand or divisor magnitude
  logic [WIDTH:0]   acc;          // Booth partial product / division remainder
  logic [WIDTH-1:0] q_r;          // multiplier being consumed / quotient being built
  logic             q_m1;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, dbz_q;

  logic [WIDTH:0]   acc_d, booth_sum, shifted, trial, m_ext;
  logic [WIDTH-1:0] q_d, opa_mag, opb_mag, quo, rem;
  logic             q_m1_d;

  assign md.hi          = hi_q;
  assign md.lo          = lo_q;
  assign md.busy        = (state != IDLE);
  assign md.done        = done_q;
  assign md.div_by_zero = dbz_q;

  always_ff @(posedge Clock) begin
    if (!Clear) state <= IDLE;
    else        state <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (md.start) state_d = RUN;
      RUN:     if (cnt == CW'(WIDTH - 1)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign opa_mag = md.opa[WIDTH-1] ? (~md.opa + 1'b1) : md.opa;
  assign opb_mag = md.opb[WIDTH-1] ? (~md.opb + 1'b1) : md.opb;

  // One extra accumulator bit keeps the most-negative x most-negative product exact.
  assign m_ext   = {m_q[WIDTH-1], m_q};
  assign shifted = {acc[WIDTH-1:0], q_r[WIDTH-1]};
  assign trial   = shifted - {1'b0, m_q};

  always_comb begin
    acc_d     = acc;
    q_d       = q_r;
    q_m1_d    = q_m1;
    booth_sum = acc;
    if (!op_q) begin
      case ({q_r[0], q_m1})
        2'b01:   booth_sum = acc + m_ext;
        2'b10:   booth_sum = acc - m_ext;
        default: booth_sum = acc;
      endcase
      acc_d  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      q_d    = {booth_sum[0], q_r[WIDTH-1:1]};
      q_m1_d = q_r[0];
    end else if (!trial[WIDTH]) begin
      acc_d = trial;
      q_d   = {q_r[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = shifted;
      q_d   = {q_r[WIDTH-2:0], 1'b0};
    end
  end

  assign quo = quo_neg_q ? (~q_r + 1'b1) : q_r;
  assign rem = rem_neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];

  // NOTE: the iteration datapath carries no reset; it is always fully loaded on the start edge before it is used.
  always_ff @(posedge Clock) begin
    if (state == IDLE && md.start) begin
      op_q      <= md.op;
      zero_q    <= md.op && (md.opb == '0);
      quo_neg_q <= md.opa[WIDTH-1] ^ md.opb[WIDTH-1];
      rem_neg_q <= md.opa[WIDTH-1];
      acc       <= '0;
      q_m1      <= 1'b0;
      m_q       <= md.op ? opb_mag : md.opa;
      q_r       <= md.op ? opa_mag : md.opb;
    end else if (state == RUN) begin
      acc  <= acc_d;
      q_r  <= q_d;
      q_m1 <= q_m1_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (md.start) begin
            cnt <= '0;
          end else begin
            if (md.HIin)  hi_q <= md.bus_in;
            if (md.LOWin) lo_q <= md.bus_in;
          end
        end
        RUN: cnt <= cnt + 1'b1;
        FINISH: begin
          done_q <= 1'b1;
          dbz_q  <= zero_q;
          // A zero divisor leaves HI/LO untouched.
          if (!zero_q) begin
            if (op_q) begin
              hi_q <= rem;
              lo_q <= quo;
            end else begin
              hi_q <= acc[WIDTH-1:0];
              lo_q <= q_r;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_hilo.sv
// Directed self-checking bench for mul_div_hilo: reset, bus loads, multiply/divide
// results, latency, divide-by-zero, abort, ignored inputs and overflow.
module tb_mul_div_hilo;

  localparam int WIDTH = 32;

  logic clk;
  logic Clear;
  int   n_checks = 0;
  int   n_fail   = 0;

  mul_div_hilo_if #(.WIDTH(WIDTH)) md ();

  mul_div_hilo #(.WIDTH(WIDTH)) dut (
    .Clock (clk),
    .Clear (Clear),
    .md    (md.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    md.start  = 1'b0;
    md.op     = 1'b0;
    md.opa    = '0;
    md.opb    = '0;
    md.bus_in = '0;
    md.HIin   = 1'b0;
    md.LOWin  = 1'b0;
  endtask

  task automatic bus_load(input logic hi_en, input logic lo_en, input logic [31:0] v);
    md.HIin   = hi_en;
    md.LOWin  = lo_en;
    md.bus_in = v;
    @(negedge clk);
    md.HIin   = 1'b0;
    md.LOWin  = 1'b0;
  endtask

  // Starts an operation at the next edge and counts edges until done.
  // At step inject_at, start(op=1) and LOWin(bus_in=99) are pulsed for one edge.
  task automatic run_op(input string tag, input logic op, input logic [31:0] a,
                        input logic [31:0] b, input int inject_at);
    int n;
    logic busy_ok;
    md.op    = op;
    md.opa   = a;
    md.opb   = b;
    md.start = 1'b1;
    @(negedge clk);
    md.start = 1'b0;
    n        = 0;
    busy_ok  = 1'b1;
    while (!md.done && n < 100) begin
      if (!md.busy) busy_ok = 1'b0;
      if (n == inject_at) begin
        md.start  = 1'b1;
        md.op     = 1'b1;
        md.LOWin  = 1'b1;
        md.bus_in = 32'd99;
      end
      @(negedge clk);
      md.start = 1'b0;
      md.LOWin = 1'b0;
      n++;
    end
    check({tag, " latency"}, n, 33);
    check({tag, " busy held"}, {31'd0, busy_ok}, 1);
    check({tag, " busy at done"}, {31'd0, md.busy}, 0);
  endtask

  initial begin
    int done_seen;
    idle_inputs();
    Clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    Clear = 1'b1;
    check("reset hi", md.hi, 0);
    check("reset lo", md.lo, 0);
    check("reset busy", {31'd0, md.busy}, 0);
    check("reset done", {31'd0, md.done}, 0);
    check("reset dbz", {31'd0, md.div_by_zero}, 0);

    bus_load(1'b0, 1'b1, 32'd10);
    check("mtlo lo", md.lo, 10);
    check("mtlo hi", md.hi, 0);

    run_op("mul 7*-3", 1'b0, 32'd7, 32'hFFFF_FFFD, -1);
    check("mul 7*-3 hi", md.hi, 32'hFFFF_FFFF);
    check("mul 7*-3 lo", md.lo, 32'hFFFF_FFEB);
    @(negedge clk);
    check("done one cycle", {31'd0, md.done}, 0);

    run_op("div -17/5", 1'b1, 32'hFFFF_FFEF, 32'd5, -1);
    check("div -17/5 lo", md.lo, 32'hFFFF_FFFD);
    check("div -17/5 hi", md.hi, 32'hFFFF_FFFE);
    check("div -17/5 dbz", {31'd0, md.div_by_zero}, 0);

    bus_load(1'b1, 1'b0, 32'h55);
    bus_load(1'b0, 1'b1, 32'd10);
    check("preload hi", md.hi, 32'h55);
    run_op("div by 0", 1'b1, 32'd123, 32'd0, -1);
    check("div0 dbz", {31'd0, md.div_by_zero}, 1);
    check("div0 hi", md.hi, 32'h55);
    check("div0 lo", md.lo, 10);

    run_op("mul -1*-1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check("mul -1*-1 hi", md.hi, 0);
    check("mul -1*-1 lo", md.lo, 1);
    check("mul clears dbz", {31'd0, md.div_by_zero}, 0);

    // Abort: Clear low at iteration 10 of a multiply.
    bus_load(1'b1, 1'b1, 32'h1234);
    md.op    = 1'b0;
    md.opa   = 32'd5;
    md.opb   = 32'd6;
    md.start = 1'b1;
    @(negedge clk);
    md.start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort busy before", {31'd0, md.busy}, 1);
    Clear = 1'b0;
    @(negedge clk);
    Clear = 1'b1;
    check("abort hi", md.hi, 0);
    check("abort lo", md.lo, 0);
    check("abort busy", {31'd0, md.busy}, 0);
    done_seen = 0;
    repeat (40) begin
      if (md.done) done_seen++;
      @(negedge clk);
    end
    check("abort no done", done_seen, 0);

    run_op("mul min*min", 1'b0, 32'h8000_0000, 32'h8000_0000, -1);
    check("mul min*min hi", md.hi, 32'h4000_0000);
    check("mul min*min lo", md.lo, 0);

    run_op("mul 3*4 inject", 1'b0, 32'd3, 32'd4, 5);
    check("mul 3*4 hi", md.hi, 0);
    check("mul 3*4 lo", md.lo, 12);
    @(negedge clk);
    check("no restart busy", {31'd0, md.busy}, 0);

    run_op("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("div ovf lo", md.lo, 32'h8000_0000);
    check("div ovf hi", md.hi, 0);
    check("div ovf dbz", {31'd0, md.div_by_zero}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
